// File: rtl/w3_update_module_if.sv
// Bus bundle between the training controller and the layer-3 weight update block.
// Latency: none, wires only; w3_rd is combinational from the weight bank.
// Backpressure: none; the producer must hold off accumulation while busy is high.
// Optional W3_SAT_FLAG_EN adds the sticky sat_flag signal.
interface w3_update_module_if #(
    parameter int IW = 2
);
    logic [3:0]    step;
    logic [3:0]    controller;
    logic [IW-1:0] sel;
    logic [15:0]   deltaw3;
    logic          init_en;
    logic [15:0]   init_w;
    logic [IW-1:0] rd_sel;
    logic [15:0]   w3_rd;
    logic          busy;
    logic          done;
`ifdef W3_SAT_FLAG_EN
    logic          sat_flag;

    modport master (
        output step, controller, sel, deltaw3, init_en, init_w, rd_sel,
        input  w3_rd, busy, done, sat_flag
    );
    modport slave (
        input  step, controller, sel, deltaw3, init_en, init_w, rd_sel,
        output w3_rd, busy, done, sat_flag
    );
`else
    modport master (
        output step, controller, sel, deltaw3, init_en, init_w, rd_sel,
        input  w3_rd, busy, done
    );
    modport slave (
        input  step, controller, sel, deltaw3, init_en, init_w, rd_sel,
        output w3_rd, busy, done
    );
`endif
endinterface

// File: rtl/w3_update_module.sv
// Mini-batch accumulator and saturating averaged update of NW layer-3 Q6.10 weights.
// Latency: accumulate/init 1 cycle; batch apply NW cycles after the final end-of-sample, done 1 cycle pulse.
// Backpressure: none; inputs are dropped while busy (APPLY). Optional W3_SAT_FLAG_EN adds sticky sat_flag.
module w3_update_module #(
    parameter int NW    = 4,
    parameter int BATCH = 4
) (
    input  logic         clk,
    input  logic         rst,
    w3_update_module_if.slave bus
);
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;
    localparam int SH = $clog2(BATCH);
    localparam int CW = (SH > 0) ? SH : 1;

    localparam logic [3:0] CTRL_ACC = 4'd10;
    localparam logic [3:0] CTRL_EOS = 4'd11;

    typedef enum logic {ST_IDLE = 1'b0, ST_APPLY = 1'b1} state_t;

    state_t               state_q, state_d;
    logic signed [15:0]   w_q   [NW];
    logic signed [15:0]   w_d   [NW];
    logic signed [19:0]   acc_q [NW];
    logic signed [19:0]   acc_d [NW];
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        ai_q, ai_d;
    logic                 done_q, done_d;

    logic signed [19:0]   acc_sh;
    logic signed [20:0]   diff;
    logic signed [15:0]   w_new;
    logic                 clip;

`ifdef W3_SAT_FLAG_EN
    logic                 sat_q, sat_d;
`endif

    // Averaged, saturated new value for the weight currently being applied
    always_comb begin
        acc_sh = acc_q[ai_q] >>> SH;
        diff   = {{5{w_q[ai_q][15]}}, w_q[ai_q]} - {acc_sh[19], acc_sh};
        w_new  = diff[15:0];
        clip   = 1'b0;
        if (diff > 21'sd32767) begin
            w_new = 16'sh7FFF;
            clip  = 1'b1;
        end else if (diff < -21'sd32768) begin
            w_new = -16'sh8000;
            clip  = 1'b1;
        end
    end

    // Next-state: init / accumulate / sample count in IDLE, one weight per cycle in APPLY
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ai_d    = ai_q;
        done_d  = 1'b0;
`ifdef W3_SAT_FLAG_EN
        sat_d   = sat_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.init_en) begin
                    if (int'(bus.sel) < NW) begin
                        w_d[bus.sel]   = bus.init_w;
                        acc_d[bus.sel] = '0;
                    end
`ifdef W3_SAT_FLAG_EN
                    sat_d = 1'b0;
`endif
                end else if (bus.step != 4'd0) begin
                    if (bus.controller == CTRL_ACC) begin
                        if (int'(bus.sel) < NW) begin
                            acc_d[bus.sel] = acc_q[bus.sel]
                                           + {{4{bus.deltaw3[15]}}, bus.deltaw3};
                        end
                    end else if (bus.controller == CTRL_EOS) begin
                        if (cnt_q == CW'(BATCH - 1)) begin
                            cnt_d   = '0;
                            ai_d    = '0;
                            state_d = ST_APPLY;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
            end
            ST_APPLY: begin
                w_d[ai_q]   = w_new;
                acc_d[ai_q] = '0;
`ifdef W3_SAT_FLAG_EN
                if (clip) sat_d = 1'b1;
`endif
                if (ai_q == IW'(NW - 1)) begin
                    ai_d    = '0;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    ai_d = ai_q + IW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous reset to an empty, idle bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            w_q     <= '{default: '0};
            acc_q   <= '{default: '0};
            cnt_q   <= '0;
            ai_q    <= '0;
            done_q  <= 1'b0;
`ifdef W3_SAT_FLAG_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ai_q    <= ai_d;
            done_q  <= done_d;
`ifdef W3_SAT_FLAG_EN
            sat_q   <= sat_d;
`endif
        end
    end

    assign bus.w3_rd = w_q[bus.rd_sel];
    assign bus.busy  = (state_q == ST_APPLY);
    assign bus.done  = done_q;
`ifdef W3_SAT_FLAG_EN
    assign bus.sat_flag = sat_q;
`endif

endmodule

// File: tb/tb_w3_update_module.sv
// Self-checking bench for w3_update_module: expected weights are queued when a batch is driven
// and compared against w3_rd once the done pulse appears.
module tb_w3_update_module;
    localparam int NW = 4;
    localparam int BATCH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    w3_update_module_if #(.IW(2)) bus ();

    w3_update_module #(.NW(NW), .BATCH(BATCH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          idx;
        logic [15:0] val;
    } sb_t;

    sb_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_init(input int idx, input logic [15:0] val);
        bus.sel     = 2'(idx);
        bus.init_w  = val;
        bus.init_en = 1'b1;
        tick();
        bus.init_en = 1'b0;
    endtask

    task automatic do_acc(input int idx, input logic [15:0] d);
        bus.step       = 4'd3;
        bus.controller = 4'd10;
        bus.sel        = 2'(idx);
        bus.deltaw3    = d;
        tick();
        bus.controller = 4'd0;
    endtask

    task automatic do_eos();
        bus.step       = 4'd3;
        bus.controller = 4'd11;
        tick();
        bus.controller = 4'd0;
    endtask

    // Four samples of one delta on one weight; returns sampled #1 after the final end-of-sample edge.
    task automatic run_batch(input int idx, input logic [15:0] d);
        for (int s = 0; s < BATCH; s++) begin
            do_acc(idx, d);
            do_eos();
        end
    endtask

    task automatic push(input string tag, input int idx, input logic [15:0] val);
        sb_t e;
        e.tag = tag;
        e.idx = idx;
        e.val = val;
        sb.push_back(e);
    endtask

    // Count busy cycles until done; controller inputs are released as soon as done is seen.
    task automatic wait_done(input string tag);
        int  busy_cnt = 0;
        int  lat = 0;
        bit  seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.done) begin
                seen = 1;
            end else begin
                if (bus.busy) busy_cnt++;
                tick();
                lat++;
            end
        end
        bus.controller = 4'd0;
        bus.step       = 4'd0;
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(NW));
        chk({tag, "_done_latency"}, 32'(lat), 32'(NW));
        while (sb.size() > 0) begin
            sb_t e;
            e = sb.pop_front();
            bus.rd_sel = 2'(e.idx);
            #1;
            chk(e.tag, 32'(bus.w3_rd), 32'(e.val));
        end
        tick();
        chk({tag, "_done_drop"}, 32'(bus.done), 32'd0);
        tick();
        chk({tag, "_done_once"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        bus.step       = '0;
        bus.controller = '0;
        bus.sel        = '0;
        bus.deltaw3    = '0;
        bus.init_en    = 1'b0;
        bus.init_w     = '0;
        bus.rd_sel     = '0;

        // 1: reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        for (int i = 0; i < NW; i++) begin
            bus.rd_sel = 2'(i);
            #1;
            chk($sformatf("rst_w%0d", i), 32'(bus.w3_rd), 32'd0);
        end
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
`ifdef W3_SAT_FLAG_EN
        chk("rst_sat", 32'(bus.sat_flag), 32'd0);
`endif

        // 2: 1.0 - avg(0.125) = 0.875
        do_init(0, 16'h0400);
        run_batch(0, 16'h0080);
        chk("b2_busy_start", 32'(bus.busy), 32'd1);
        push("b2_w0", 0, 16'h0380);
        push("b2_w1", 1, 16'h0000);
        push("b2_w2", 2, 16'h0000);
        push("b2_w3", 3, 16'h0000);
        wait_done("b2");

        // 3: negative delta raises the weight
        do_init(1, 16'h0000);
        run_batch(1, 16'hFF00);
        push("b3_w0", 0, 16'h0380);
        push("b3_w1", 1, 16'h0100);
        push("b3_w2", 2, 16'h0000);
        push("b3_w3", 3, 16'h0000);
        wait_done("b3");

        // 4: positive clamp
        do_init(2, 16'h7F00);
        run_batch(2, 16'hC000);
        push("b4_w0", 0, 16'h0380);
        push("b4_w1", 1, 16'h0100);
        push("b4_w2", 2, 16'h7FFF);
        push("b4_w3", 3, 16'h0000);
        wait_done("b4");
`ifdef W3_SAT_FLAG_EN
        chk("b4_sat_set", 32'(bus.sat_flag), 32'd1);
        repeat (3) tick();
        chk("b4_sat_sticky", 32'(bus.sat_flag), 32'd1);
`endif

        // 5: step == 0 ignores controller codes; accumulation during busy is dropped
        do_init(3, 16'h0200);
`ifdef W3_SAT_FLAG_EN
        chk("b5_sat_clear", 32'(bus.sat_flag), 32'd0);
`endif
        begin
            int busy_hits = 0;
            bus.step    = 4'd0;
            bus.sel     = 2'd0;
            bus.deltaw3 = 16'h0100;
            for (int i = 0; i < 8; i++) begin
                bus.controller = (i % 2 == 0) ? 4'd10 : 4'd11;
                tick();
                if (bus.busy) busy_hits++;
            end
            bus.controller = 4'd0;
            chk("b5_step0_busy", 32'(busy_hits), 32'd0);
        end
        for (int s = 0; s < BATCH - 1; s++) begin
            do_acc(3, 16'h0040);
            do_eos();
        end
        chk("b5_cnt_held", 32'(bus.busy), 32'd0);
        do_acc(3, 16'h0040);
        do_eos();
        chk("b5_busy_start", 32'(bus.busy), 32'd1);
        bus.step       = 4'd3;
        bus.controller = 4'd10;
        bus.sel        = 2'd3;
        bus.deltaw3    = 16'h0100;
        push("b5_w0", 0, 16'h0380);
        push("b5_w1", 1, 16'h0100);
        push("b5_w2", 2, 16'h7FFF);
        push("b5_w3", 3, 16'h01C0);
        wait_done("b5");

        // 6: asynchronous reset in the 2nd APPLY cycle, then a clean batch
        do_init(0, 16'h0400);
        run_batch(0, 16'h0080);
        tick();
        bus.rd_sel = 2'd0;
        #2;
        rst = 1'b1;
        #1;
        chk("b6_rst_busy", 32'(bus.busy), 32'd0);
        chk("b6_rst_w0", 32'(bus.w3_rd), 32'd0);
        chk("b6_rst_done", 32'(bus.done), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("b6_no_done", 32'(bus.done), 32'd0);
        do_init(0, 16'h0400);
        run_batch(0, 16'h0080);
        push("b6_w0", 0, 16'h0380);
        push("b6_w1", 1, 16'h0000);
        push("b6_w2", 2, 16'h0000);
        push("b6_w3", 3, 16'h0000);
        wait_done("b6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
